// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode constants (single source with the ALU),
// arbiter FSM encoding and the opcode legality check.
package alu_pkg;

    localparam int ALU_CTRL_W = 4;

    localparam logic [ALU_CTRL_W-1:0] ALU_AND   = 4'b0000;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR    = 4'b0001;
    localparam logic [ALU_CTRL_W-1:0] ALU_ADD   = 4'b0010;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB   = 4'b0110;
    localparam logic [ALU_CTRL_W-1:0] ALU_PASSB = 4'b0111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic opcode_legal(input logic [ALU_CTRL_W-1:0] op);
        return op inside {ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_PASSB};
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req at or after ptr, wrapping
// modulo NREQ; gnt is one-hot (or zero when nothing requests).
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id,
    output logic            any
);

    logic [IDW-1:0] idx;

    always_comb begin
        // NOTE: every variable gets a default first so the search loop cannot infer a latch.
        gnt    = '0;
        gnt_id = '0;
        any    = 1'b0;
        idx    = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = IDW'((int'(ptr) + i) % NREQ);
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = idx;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU among NREQ requesters, one op in flight.
// Optional opcode checking and the RspErr port are enabled by ALU_OPCHK_EN.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int n    = 64,
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                  CLK,
    input  logic                  ResetL,
    input  logic [NREQ-1:0]       ReqValid,
    output logic [NREQ-1:0]       ReqReady,
    input  logic [NREQ*n-1:0]     ReqBusA,
    input  logic [NREQ*n-1:0]     ReqBusB,
    input  logic [NREQ*4-1:0]     ReqCtrl,
    output logic [n-1:0]          AluBusA,
    output logic [n-1:0]          AluBusB,
    output logic [ALU_CTRL_W-1:0] AluCtrl,
    input  logic [n-1:0]          AluBusW,
    input  logic                  AluZero,
    output logic                  RspValid,
    input  logic                  RspReady,
    output logic [n-1:0]          RspBusW,
    output logic                  RspZero,
`ifdef ALU_OPCHK_EN
    output logic                  RspErr,
`endif
    output logic [IDW-1:0]        RspId
);

    state_t                  state_q, state_d;
    logic [IDW-1:0]          ptr_q, ptr_d;
    logic [IDW-1:0]          rsp_id_q, rsp_id_d;
    logic [n-1:0]            alu_a_q, alu_a_d;
    logic [n-1:0]            alu_b_q, alu_b_d;
    logic [ALU_CTRL_W-1:0]   alu_ctrl_q, alu_ctrl_d;
    logic [n-1:0]            rsp_w_q, rsp_w_d;
    logic                    rsp_zero_q, rsp_zero_d;
`ifdef ALU_OPCHK_EN
    logic                    err_q, err_d;
`endif

    logic [NREQ-1:0]         win_gnt;
    logic [IDW-1:0]          win_id;
    logic                    win_any;
    logic [n-1:0]            win_a, win_b;
    logic [ALU_CTRL_W-1:0]   win_ctrl;

    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .req    (ReqValid),
        .ptr    (ptr_q),
        .gnt    (win_gnt),
        .gnt_id (win_id),
        .any    (win_any)
    );

    assign win_a    = ReqBusA[int'(win_id)*n +: n];
    assign win_b    = ReqBusB[int'(win_id)*n +: n];
    assign win_ctrl = ReqCtrl[int'(win_id)*ALU_CTRL_W +: ALU_CTRL_W];

    always_ff @(posedge CLK or negedge ResetL) begin
        if (!ResetL) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            rsp_id_q   <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_ctrl_q <= ALU_PASSB;
            rsp_w_q    <= '0;
            rsp_zero_q <= 1'b0;
`ifdef ALU_OPCHK_EN
            err_q      <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking so every flop samples the same pre-edge values.
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rsp_id_q   <= rsp_id_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_ctrl_q <= alu_ctrl_d;
            rsp_w_q    <= rsp_w_d;
            rsp_zero_q <= rsp_zero_d;
`ifdef ALU_OPCHK_EN
            err_q      <= err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (win_any) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (RspReady) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand registers load only on accept, so the ALU inputs stay quiet when idle.
    always_comb begin
        ptr_d      = ptr_q;
        rsp_id_d   = rsp_id_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_ctrl_d = alu_ctrl_q;
        rsp_w_d    = rsp_w_q;
        rsp_zero_d = rsp_zero_q;
`ifdef ALU_OPCHK_EN
        err_d      = err_q;
`endif
        if (state_q == IDLE && win_any) begin
            alu_a_d    = win_a;
            alu_b_d    = win_b;
            alu_ctrl_d = win_ctrl;
            rsp_id_d   = win_id;
            ptr_d      = (win_id == IDW'(NREQ - 1)) ? '0 : win_id + IDW'(1);
`ifdef ALU_OPCHK_EN
            err_d      = !opcode_legal(win_ctrl);
            if (err_d) begin
                alu_ctrl_d = ALU_PASSB;
                alu_b_d    = '0;
            end
`endif
        end
        if (state_q == EXEC) begin
            rsp_w_d    = AluBusW;
            rsp_zero_d = AluZero;
`ifdef ALU_OPCHK_EN
            if (err_q) begin
                rsp_w_d    = '0;
                rsp_zero_d = 1'b1;
            end
`endif
        end
    end

    // Grants are masked while reset is held so no handshake completes during reset.
    always_comb begin
        ReqReady = (state_q == IDLE && ResetL) ? win_gnt : '0;
        RspValid = (state_q == RESP);
    end

    assign AluBusA = alu_a_q;
    assign AluBusB = alu_b_q;
    assign AluCtrl = alu_ctrl_q;
    assign RspBusW = rsp_w_q;
    assign RspZero = rsp_zero_q;
    assign RspId   = rsp_id_q;
`ifdef ALU_OPCHK_EN
    assign RspErr  = err_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU attached; covers
// ALU_OPCHK_EN when the macro is defined for the build.
module tb_alu_arbiter;

    localparam int N    = 64;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic            CLK = 1'b0;
    logic            ResetL = 1'b0;
    logic [NREQ-1:0] ReqValid = '0;
    logic [NREQ-1:0] ReqReady;
    logic [NREQ*N-1:0] ReqBusA = '0;
    logic [NREQ*N-1:0] ReqBusB = '0;
    logic [NREQ*4-1:0] ReqCtrl = '0;
    logic [N-1:0]    AluBusA, AluBusB, AluBusW;
    logic [3:0]      AluCtrl;
    logic            AluZero;
    logic            RspValid;
    logic            RspReady = 1'b1;
    logic [N-1:0]    RspBusW;
    logic            RspZero;
    logic [IDW-1:0]  RspId;
`ifdef ALU_OPCHK_EN
    logic            RspErr;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    alu_arbiter #(.n(N), .NREQ(NREQ), .IDW(IDW)) dut (
        .CLK      (CLK),
        .ResetL   (ResetL),
        .ReqValid (ReqValid),
        .ReqReady (ReqReady),
        .ReqBusA  (ReqBusA),
        .ReqBusB  (ReqBusB),
        .ReqCtrl  (ReqCtrl),
        .AluBusA  (AluBusA),
        .AluBusB  (AluBusB),
        .AluCtrl  (AluCtrl),
        .AluBusW  (AluBusW),
        .AluZero  (AluZero),
        .RspValid (RspValid),
        .RspReady (RspReady),
        .RspBusW  (RspBusW),
        .RspZero  (RspZero),
`ifdef ALU_OPCHK_EN
        .RspErr   (RspErr),
`endif
        .RspId    (RspId)
    );

    always #5 CLK = ~CLK;

    // Behavioural ALU: AND, OR, ADD, SUB, PASSB; anything else yields 0.
    always_comb begin
        case (AluCtrl)
            4'b0000: AluBusW = AluBusA & AluBusB;
            4'b0001: AluBusW = AluBusA | AluBusB;
            4'b0010: AluBusW = AluBusA + AluBusB;
            4'b0110: AluBusW = AluBusA - AluBusB;
            4'b0111: AluBusW = AluBusB;
            default: AluBusW = '0;
        endcase
    end
    assign AluZero = (AluBusW == '0);

    task automatic cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_req(input int i, input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic [3:0] ctrl);
        ReqValid[i] = 1'b1;
        ReqBusA[i*N +: N] = a;
        ReqBusB[i*N +: N] = b;
        ReqCtrl[i*4 +: 4] = ctrl;
    endtask

    task automatic clear_reqs();
        ReqValid = '0;
    endtask

    task automatic apply_reset();
        ResetL = 1'b0;
        clear_reqs();
        repeat (2) cycle();
        ResetL = 1'b1;
        cycle();
    endtask

    task automatic test_reset();
        ResetL = 1'b0;
        repeat (2) cycle();
        tests_run++; if (ReqReady !== 4'b0000) begin tests_failed++; $display("FAIL rst_req_ready: got %b want 0000", ReqReady); end
        tests_run++; if (RspValid !== 1'b0) begin tests_failed++; $display("FAIL rst_rsp_valid: got %b want 0", RspValid); end
        tests_run++; if (RspBusW !== 64'd0 || RspZero !== 1'b0 || RspId !== 2'd0) begin tests_failed++; $display("FAIL rst_rsp: got w=%0h z=%b id=%0d want 0/0/0", RspBusW, RspZero, RspId); end
        tests_run++; if (AluBusA !== 64'd0 || AluBusB !== 64'd0) begin tests_failed++; $display("FAIL rst_alu_bus: got a=%0h b=%0h want 0/0", AluBusA, AluBusB); end
        tests_run++; if (AluCtrl !== 4'b0111) begin tests_failed++; $display("FAIL rst_alu_ctrl: got %b want 0111", AluCtrl); end
`ifdef ALU_OPCHK_EN
        tests_run++; if (RspErr !== 1'b0) begin tests_failed++; $display("FAIL rst_rsp_err: got %b want 0", RspErr); end
`endif
        ResetL = 1'b1;
        cycle();
    endtask

    task automatic test_single();
        RspReady = 1'b1;
        set_req(0, 64'd5, 64'd3, 4'b0010);
        #1;
        tests_run++; if (ReqReady !== 4'b0001) begin tests_failed++; $display("FAIL single_grant: got %b want 0001", ReqReady); end
        cycle();
        clear_reqs();
        tests_run++; if (RspValid !== 1'b0 || ReqReady !== 4'b0000) begin tests_failed++; $display("FAIL single_exec: got valid=%b ready=%b want 0/0000", RspValid, ReqReady); end
        tests_run++; if (AluBusA !== 64'd5 || AluBusB !== 64'd3 || AluCtrl !== 4'b0010) begin tests_failed++; $display("FAIL single_alu_in: got a=%0h b=%0h c=%b want 5/3/0010", AluBusA, AluBusB, AluCtrl); end
        cycle();
        tests_run++; if (RspValid !== 1'b1) begin tests_failed++; $display("FAIL single_latency: got valid=%b want 1", RspValid); end
        tests_run++; if (RspBusW !== 64'd8 || RspZero !== 1'b0 || RspId !== 2'd0) begin tests_failed++; $display("FAIL single_rsp: got w=%0h z=%b id=%0d want 8/0/0", RspBusW, RspZero, RspId); end
        cycle();
        tests_run++; if (RspValid !== 1'b0) begin tests_failed++; $display("FAIL single_handshake: got valid=%b want 0", RspValid); end
    endtask

    task automatic test_sub_zero();
        set_req(1, 64'h1234, 64'h1234, 4'b0110);
        cycle();
        clear_reqs();
        cycle();
        tests_run++; if (RspBusW !== 64'd0 || RspZero !== 1'b1 || RspId !== 2'd1) begin tests_failed++; $display("FAIL sub_zero: got w=%0h z=%b id=%0d want 0/1/1", RspBusW, RspZero, RspId); end
        cycle();
    endtask

    task automatic test_round_robin();
        int exp_id;
        apply_reset();
        RspReady = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 64'(i), 64'd100, 4'b0010);
        #1;
        for (int k = 0; k < 5; k++) begin
            exp_id = k % NREQ;
            tests_run++; if (ReqReady !== 4'(1 << exp_id)) begin tests_failed++; $display("FAIL rr_grant%0d: got %b want %b", k, ReqReady, 4'(1 << exp_id)); end
            cycle();
            tests_run++; if (ReqReady !== 4'b0000) begin tests_failed++; $display("FAIL rr_exec_ready%0d: got %b want 0000", k, ReqReady); end
            cycle();
            tests_run++; if (RspValid !== 1'b1 || RspId !== 2'(exp_id) || RspBusW !== 64'(100 + exp_id)) begin tests_failed++; $display("FAIL rr_rsp%0d: got v=%b id=%0d w=%0d want 1/%0d/%0d", k, RspValid, RspId, RspBusW, exp_id, 100 + exp_id); end
            cycle();
        end
        clear_reqs();
        // Pending grant was for requester 0 -> finish it so the pointer is left at 1.
    endtask

    task automatic test_backpressure();
        // Pointer is 1 after the rotation test.
        RspReady = 1'b0;
        set_req(1, 64'd20, 64'd22, 4'b0010);
        set_req(2, 64'hF0, 64'h0F, 4'b0001);
        cycle();
        cycle();
        for (int k = 0; k < 5; k++) begin
            tests_run++; if (RspValid !== 1'b1 || RspBusW !== 64'd42 || RspId !== 2'd1 || ReqReady !== 4'b0000) begin tests_failed++; $display("FAIL bp_hold%0d: got v=%b w=%0d id=%0d rdy=%b want 1/42/1/0000", k, RspValid, RspBusW, RspId, ReqReady); end
            cycle();
        end
        RspReady = 1'b1;
        #1;
        tests_run++; if (RspValid !== 1'b1 || ReqReady !== 4'b0000) begin tests_failed++; $display("FAIL bp_release: got v=%b rdy=%b want 1/0000", RspValid, ReqReady); end
        cycle();
        tests_run++; if (ReqReady !== 4'b0100) begin tests_failed++; $display("FAIL bp_resume: got %b want 0100", ReqReady); end
        cycle();
        clear_reqs();
        cycle();
        tests_run++; if (RspBusW !== 64'hFF || RspId !== 2'd2) begin tests_failed++; $display("FAIL bp_next_rsp: got w=%0h id=%0d want ff/2", RspBusW, RspId); end
        cycle();
    endtask

    task automatic test_reset_mid();
        // Pointer is 3; requester 1 wins and would move it to 2.
        set_req(1, 64'd1, 64'd1, 4'b0010);
        cycle();
        ResetL = 1'b0;
        #1;
        tests_run++; if (ReqReady !== 4'b0000 || RspValid !== 1'b0) begin tests_failed++; $display("FAIL mid_rst_hs: got rdy=%b v=%b want 0000/0", ReqReady, RspValid); end
        tests_run++; if (AluBusA !== 64'd0 || AluBusB !== 64'd0 || AluCtrl !== 4'b0111 || RspId !== 2'd0) begin tests_failed++; $display("FAIL mid_rst_vals: got a=%0h b=%0h c=%b id=%0d want 0/0/0111/0", AluBusA, AluBusB, AluCtrl, RspId); end
        clear_reqs();
        cycle();
        ResetL = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            tests_run++; if (RspValid !== 1'b0) begin tests_failed++; $display("FAIL mid_no_rsp%0d: got %b want 0", k, RspValid); end
        end
        set_req(2, 64'd50, 64'd1, 4'b0010);
        set_req(0, 64'd9, 64'd4, 4'b0110);
        #1;
        tests_run++; if (ReqReady !== 4'b0001) begin tests_failed++; $display("FAIL mid_ptr_reset: got %b want 0001", ReqReady); end
        cycle();
        clear_reqs();
        cycle();
        tests_run++; if (RspValid !== 1'b1 || RspBusW !== 64'd5 || RspId !== 2'd0) begin tests_failed++; $display("FAIL mid_next_op: got v=%b w=%0d id=%0d want 1/5/0", RspValid, RspBusW, RspId); end
        cycle();
    endtask

    task automatic test_opcode();
        // Pointer is 1.
        set_req(1, 64'd7, 64'd9, 4'b1111);
        cycle();
        clear_reqs();
`ifdef ALU_OPCHK_EN
        tests_run++; if (AluCtrl !== 4'b0111 || AluBusB !== 64'd0) begin tests_failed++; $display("FAIL opchk_force: got c=%b b=%0h want 0111/0", AluCtrl, AluBusB); end
        cycle();
        tests_run++; if (RspBusW !== 64'd0 || RspZero !== 1'b1 || RspErr !== 1'b1 || RspId !== 2'd1) begin tests_failed++; $display("FAIL opchk_rsp: got w=%0h z=%b e=%b id=%0d want 0/1/1/1", RspBusW, RspZero, RspErr, RspId); end
        cycle();
        set_req(2, 64'hC, 64'hA, 4'b0000);
        cycle();
        clear_reqs();
        cycle();
        tests_run++; if (RspBusW !== 64'd8 || RspErr !== 1'b0 || RspId !== 2'd2) begin tests_failed++; $display("FAIL opchk_legal: got w=%0h e=%b id=%0d want 8/0/2", RspBusW, RspErr, RspId); end
        cycle();
`else
        tests_run++; if (AluCtrl !== 4'b1111 || AluBusB !== 64'd9) begin tests_failed++; $display("FAIL op_passthru: got c=%b b=%0h want 1111/9", AluCtrl, AluBusB); end
        cycle();
        tests_run++; if (RspValid !== 1'b1 || RspId !== 2'd1) begin tests_failed++; $display("FAIL op_passthru_rsp: got v=%b id=%0d want 1/1", RspValid, RspId); end
        cycle();
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_sub_zero();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_opcode();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one 64-bit ALU instance between NREQ independent requesters.
- Round-robin arbitration; one operation in flight at a time.
- Operands and opcode registered toward the ALU; result and Zero captured and returned with a valid/ready handshake.
- Sits between the datapath issue stages (integer pipe, address generation, branch compare) and the single ALU.

Parameters:
- n, 64, ALU data width
- NREQ, 4, number of requesters (2..8)
- IDW, 2, requester ID width; must equal clog2(NREQ)

Ports:
- CLK  in  1  clock, rising edge
- ResetL  in  1  asynchronous active-low reset
- ReqValid  in  NREQ  per-requester request valid
- ReqReady  out  NREQ  per-requester accept; one-hot or zero
- ReqBusA  in  NREQ*n  packed operand A; requester i at bits [i*n +: n]
- ReqBusB  in  NREQ*n  packed operand B
- ReqCtrl  in  NREQ*4  packed 4-bit ALU opcode
- AluBusA  out  n  operand A driven to the ALU
- AluBusB  out  n  operand B driven to the ALU
- AluCtrl  out  4  opcode driven to the ALU
- AluBusW  in  n  ALU result, combinational
- AluZero  in  1  ALU zero flag
- RspValid  out  1  response valid
- RspReady  in  1  response accept
- RspBusW  out  n  captured result
- RspZero  out  1  captured zero flag
- RspId  out  IDW  index of the requester that owns the response

Behaviour:
- Reset (ResetL low, asynchronous): state IDLE, ReqReady=0, RspValid=0, RspBusW=0, RspZero=0, RspId=0, AluBusA=0, AluBusB=0, AluCtrl=4'b0111 (PassB), round-robin pointer=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - ReqReady is combinational: one-hot on the winner when any ReqValid is set.
  - Winner = first set ReqValid at or after the pointer, wrapping modulo NREQ.
  - On the edge where the winner is accepted: latch its A/B/Ctrl into the AluBus*/AluCtrl registers and its index into RspId, move pointer to winner+1 (wrap NREQ-1 -> 0), go to EXEC.
- EXEC: one cycle for ALU settle. At the end of EXEC, capture AluBusW and AluZero into RspBusW/RspZero, set RspValid, go to RESP.
- RESP: hold RspValid and all Rsp* outputs stable until RspValid & RspReady, then go to IDLE.
- ReqReady is 0 in EXEC and RESP.
- Latency: accept edge at cycle t, RspValid high from cycle t+2. Throughput is one op per 3 cycles when RspReady is held high.
- AluBus*/AluCtrl hold their last values outside EXEC; there is no toggling when idle.
- A requester deasserting ReqValid without handshake is legal; arbitration re-evaluates every IDLE cycle.
- Simultaneous requests: exactly one grant per accept. Losers keep ReqValid and are served in rotation, so no starvation: worst case NREQ-1 intervening grants.
- Reset mid-operation: the in-flight op is dropped, no response is produced, all state returns to reset values.
- Zero is taken from the ALU; it is not recomputed here.

Optional Feature:
- Macro: ALU_OPCHK_EN.
- When defined:
  - Opcodes outside {0000, 0010, 0110, 0111, 0001} are illegal.
  - An illegal request is still accepted and still returns a response, but AluCtrl is forced to 0111 with AluBusB=0.
  - The response carries RspBusW=0 and RspZero=1.
  - An extra output port RspErr (1 bit) is 1 for that response; reset value 0.
- When not defined: the RspErr port does not exist and opcodes pass through unchecked. Behaviour for undecoded opcodes is whatever the ALU holds.

Decomposition:
- Shared package alu_pkg holds:
  - opcode constants ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_PASSB, the single source shared with the ALU;
  - FSM state encoding (IDLE=2'd0, EXEC=2'd1, RESP=2'd2);
  - ALU_CTRL_W=4.
- One natural sub-module: rr_pick. It is a combinational round-robin picker with inputs req[NREQ] and ptr[IDW], and outputs gnt one-hot, gnt_id and any.

Test Plan:
- Single requester 0: A=5, B=3, Ctrl=0010, RspReady=1 -> ReqReady[0] at t, RspValid at t+2 with RspBusW=8, RspZero=0, RspId=0.
- SUB to zero: A=B=64'h1234, Ctrl=0110 -> RspBusW=0, RspZero=1.
- All 4 requesters valid continuously after reset -> grant order 0,1,2,3,0; one accept per 3 cycles.
- Backpressure: RspReady=0 for 5 cycles in RESP -> RspValid/RspBusW stable, ReqReady=0 throughout, no new accept; accept resumes the cycle after the handshake.
- ResetL pulsed low during EXEC -> RspValid never asserts, outputs return to reset values, pointer=0; the next request is served normally.
- With ALU_OPCHK_EN, Ctrl=1111, A=7, B=9 -> RspBusW=0, RspZero=1, RspErr=1. The next legal op has RspErr=0.
